normal_reorder_buffer: RTL

Retire side of the ray-direction normalization pipeline. Hands out sequential tags to incoming rays and accepts normalized directions from the DIV_COUNT divider clusters in any order. It stores each result in the slot indexed by its tag and releases results strictly in allocation order over a valid/ready output. A slot's tag becomes reusable only after that slot retires.

---
 rtl/normal_reorder_buffer_pkg.sv | 28 ++
 rtl/normal_reorder_buffer_if.sv | 36 +++
 rtl/normal_reorder_buffer_write_select.sv | 35 +++
 rtl/normal_reorder_buffer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/normal_reorder_buffer_pkg.sv
// Shared types for the ray-direction normalization retire stage.
// `WIDTH and `TAG_SIZE may be overridden on the command line before this file.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 64
`endif

package normal_reorder_buffer_pkg;

  localparam int WIDTH    = `WIDTH;
  localparam int TAG_SIZE = `TAG_SIZE;
  localparam int TAG_W    = $clog2(`TAG_SIZE);

  typedef struct packed {
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
  } RayDirection;

  typedef struct packed {
    logic        alloc;
    logic        done;
    RayDirection dir;
  } NrbSlot;

endpackage

// File: rtl/normal_reorder_buffer_if.sv
// Tag allocation, divider result and in-order retire signals of the reorder buffer.
// Handshake: a retire happens on every rising edge where out_valid && out_ready;
// out_valid/out_dir/out_tag hold until then and never depend on out_ready.
interface normal_reorder_buffer_if
  import normal_reorder_buffer_pkg::*;
#(
  parameter int DIV_COUNT = 16
) ();

  logic                         alloc_req;
  logic                         alloc_zero;
  logic                         alloc_gnt;
  logic [TAG_W-1:0]             alloc_tag;
  logic [DIV_COUNT-1:0]         res_valid;
  logic [DIV_COUNT*TAG_W-1:0]   res_tag;
  RayDirection [DIV_COUNT-1:0]  res_dir;
  logic                         out_valid;
  logic                         out_ready;
  RayDirection                  out_dir;
  logic [TAG_W-1:0]             out_tag;
  logic [TAG_W:0]               count;
  logic                         full;
  logic                         empty;
  logic                         err;

  modport master (
    output alloc_req, alloc_zero, res_valid, res_tag, res_dir, out_ready,
    input  alloc_gnt, alloc_tag, out_valid, out_dir, out_tag, count, full, empty, err
  );

  modport slave (
    input  alloc_req, alloc_zero, res_valid, res_tag, res_dir, out_ready,
    output alloc_gnt, alloc_tag, out_valid, out_dir, out_tag, count, full, empty, err
  );

endinterface

// File: rtl/normal_reorder_buffer_write_select.sv
// Per-slot selection among the divider result ports: lowest matching port wins,
// conflict flags a second port hitting the same slot in the same cycle.
module nrb_write_select
  import normal_reorder_buffer_pkg::*;
#(
  parameter int DIV_COUNT = 16,
  parameter int SLOT      = 0
) (
  input  logic [DIV_COUNT-1:0]        res_valid,
  input  logic [DIV_COUNT*TAG_W-1:0]  res_tag,
  input  RayDirection [DIV_COUNT-1:0] res_dir,
  output logic                        we,
  output RayDirection                 dir,
  output logic                        conflict
);

  localparam logic [TAG_W-1:0] SLOT_TAG = TAG_W'(SLOT);

  always_comb begin
    we       = 1'b0;
    dir      = '0;
    conflict = 1'b0;
    for (int i = 0; i < DIV_COUNT; i++) begin
      if (res_valid[i] && (res_tag[i*TAG_W +: TAG_W] == SLOT_TAG)) begin
        if (we) begin
          conflict = 1'b1;
        end else begin
          we  = 1'b1;
          dir = res_dir[i];
        end
      end
    end
  end

endmodule

// File: rtl/normal_reorder_buffer.sv
// Reorder buffer: hands out sequential tags, accepts results in any order, retires in order.
// Define NRB_ERRCHK_EN to drop illegal result writes and raise the sticky err flag.
module normal_reorder_buffer
  import normal_reorder_buffer_pkg::*;
#(
  parameter int DIV_COUNT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  normal_reorder_buffer_if.slave  bus
);

  NrbSlot           slot_q [TAG_SIZE];
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;
  logic             err_q;

  logic [TAG_SIZE-1:0] sel_we;
  logic [TAG_SIZE-1:0] sel_conflict;
  logic [TAG_SIZE-1:0] commit;
  RayDirection         sel_dir [TAG_SIZE];

  logic   full;
  logic   alloc_fire;
  logic   retire;
  NrbSlot head_slot;

  // full uses the registered count so a slot freed this cycle is granted next cycle.
  assign full       = (count_q == (TAG_W+1)'(TAG_SIZE));
  assign alloc_fire = bus.alloc_req & ~full & ~reset;
  assign head_slot  = slot_q[head_q];
  assign retire     = head_slot.alloc & head_slot.done & bus.out_ready;

  for (genvar s = 0; s < TAG_SIZE; s++) begin : g_slot
    NrbSlot slot_r;
    logic   retire_here;
    logic   alloc_here;

    nrb_write_select #(
      .DIV_COUNT (DIV_COUNT),
      .SLOT      (s)
    ) u_sel (
      .res_valid (bus.res_valid),
      .res_tag   (bus.res_tag),
      .res_dir   (bus.res_dir),
      .we        (sel_we[s]),
      .dir       (sel_dir[s]),
      .conflict  (sel_conflict[s])
    );

`ifdef NRB_ERRCHK_EN
    assign commit[s] = sel_we[s] & slot_r.alloc & ~slot_r.done;
`else
    assign commit[s] = sel_we[s];
`endif

    assign retire_here = retire & (head_q == TAG_W'(s));
    assign alloc_here  = alloc_fire & (tail_q == TAG_W'(s));

    // Later assignments take priority: retire clears, allocation sets, result completes.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_r <= '0;
      end else begin
        if (retire_here) begin
          slot_r.alloc <= 1'b0;
          slot_r.done  <= 1'b0;
        end
        if (alloc_here) begin
          slot_r.alloc <= 1'b1;
          slot_r.done  <= bus.alloc_zero;
          if (bus.alloc_zero) begin
            slot_r.dir <= '0;
          end
        end
        if (commit[s]) begin
          slot_r.dir  <= sel_dir[s];
          slot_r.done <= 1'b1;
        end
      end
    end

    assign slot_q[s] = slot_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire) begin
        tail_q <= tail_q + 1'b1;
      end
      if (retire) begin
        head_q <= head_q + 1'b1;
      end
      unique case ({alloc_fire, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef NRB_ERRCHK_EN
  logic [TAG_SIZE-1:0] illegal;

  assign illegal = (sel_we & ~commit) | sel_conflict;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|illegal) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_conflict;

  assign unused_conflict = |sel_conflict;
  assign err_q           = 1'b0;
`endif

  assign bus.alloc_gnt = alloc_fire;
  assign bus.alloc_tag = tail_q;
  assign bus.out_valid = head_slot.alloc & head_slot.done;
  assign bus.out_dir   = head_slot.dir;
  assign bus.out_tag   = head_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = (count_q == '0);
  assign bus.err       = err_q;

endmodule
